// File: rtl/mips_mdu_pkg.sv
// Shared MIPS multiply/divide types: opcode and FSM state encodings.
package mips_pkg;
  localparam int XLEN_DEFAULT = 32;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } mdu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } mdu_state_e;
endpackage

// File: rtl/mips_mdu_if.sv
// Request/result bundle between the EX stage and the multiply/divide unit.
interface mips_mdu_if #(parameter int XLEN = 32);
  logic            op_valid;
  logic [2:0]      op_code;
  logic [XLEN-1:0] rs_val;
  logic [XLEN-1:0] rt_val;
  logic            cancel;
  logic            op_ready;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;

  modport master (output op_valid, op_code, rs_val, rt_val, cancel,
                  input  op_ready, busy, done, hi, lo);
  modport slave  (input  op_valid, op_code, rs_val, rt_val, cancel,
                  output op_ready, busy, done, hi, lo);
endinterface

// File: rtl/mips_mdu_divstep.sv
// One restoring-division step: shift in the next dividend bit, subtract the
// divisor if it fits.
module mips_mdu_divstep #(parameter int XLEN = 32) (
  input  logic [XLEN-1:0] i_rem,
  input  logic [XLEN-1:0] i_div,
  input  logic            i_bit,
  output logic [XLEN-1:0] o_rem,
  output logic            o_qbit
);
  logic [XLEN:0]   w_sh;
  logic [XLEN-1:0] w_sub;

  assign w_sh   = {i_rem, i_bit};
  // The result is below the divisor, so XLEN-bit wraparound arithmetic is exact.
  assign w_sub  = w_sh[XLEN-1:0] - i_div;
  assign o_qbit = (w_sh >= {1'b0, i_div});
  assign o_rem  = o_qbit ? w_sub : w_sh[XLEN-1:0];
endmodule

// File: rtl/mips_mdu.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// Optional: MIPS_MDU_FAST_MUL_EN makes MULT/MULTU single-cycle, using a
// combinational multiplier.
module mips_mdu
  import mips_pkg::*;
#(
  parameter  int XLEN  = XLEN_DEFAULT,
  localparam int CNT_W = $clog2(XLEN) + 1
) (
  input logic       clk,
  input logic       rst_n,
  mips_mdu_if.slave bus
);
  mdu_state_e      r_state, w_state_nxt;
  logic [XLEN-1:0] r_hi, r_lo;
  logic [XLEN-1:0] r_b;      // divisor or multiplicand (magnitude)
  logic [XLEN-1:0] r_acc;    // partial remainder or product high half
  logic [XLEN-1:0] r_q;      // dividend->quotient or multiplier->product low half
  logic [XLEN-1:0] r_rs;     // original dividend, used for the divide-by-zero result
  logic [CNT_W-1:0] r_cnt;
  logic            r_is_div, r_neg_q, r_neg_r, r_dz;

  logic            w_accept, w_start, w_signed, w_rs_neg, w_rt_neg;
  logic [XLEN-1:0] w_rs_abs, w_rt_abs;
  logic [XLEN-1:0] w_div_rem;
  logic            w_div_qbit;
  logic [XLEN:0]   w_mul_sum;
  logic [2*XLEN-1:0] w_prod;

  assign w_accept = bus.op_valid & (r_state == IDLE) & ~bus.cancel;
  assign w_start  = w_accept & ~bus.op_code[2];
  assign w_signed = ~bus.op_code[0] & ~bus.op_code[2];
  assign w_rs_neg = w_signed & bus.rs_val[XLEN-1];
  assign w_rt_neg = w_signed & bus.rt_val[XLEN-1];
  assign w_rs_abs = w_rs_neg ? -bus.rs_val : bus.rs_val;
  assign w_rt_abs = w_rt_neg ? -bus.rt_val : bus.rt_val;

  mips_mdu_divstep #(.XLEN(XLEN)) u_divstep (
    .i_rem  (r_acc),
    .i_div  (r_b),
    .i_bit  (r_q[XLEN-1]),
    .o_rem  (w_div_rem),
    .o_qbit (w_div_qbit)
  );

  // Shift-add multiply: add the multiplicand when the multiplier LSB is set.
  assign w_mul_sum = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_b} : '0);
  assign w_prod    = r_neg_q ? -{r_acc, r_q} : {r_acc, r_q};

`ifdef MIPS_MDU_FAST_MUL_EN
  logic [2*XLEN-1:0] w_fast_prod;
  assign w_fast_prod = {{XLEN{1'b0}}, w_rs_abs} * {{XLEN{1'b0}}, w_rt_abs};
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state: XLEN CALC steps, one FIX write-back; cancel aborts to IDLE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (w_start) begin
`ifdef MIPS_MDU_FAST_MUL_EN
        w_state_nxt = bus.op_code[1] ? CALC : FIX;
`else
        w_state_nxt = CALC;
`endif
      end
      CALC: if (bus.cancel)                         w_state_nxt = IDLE;
            else if (r_cnt == CNT_W'(XLEN - 1))     w_state_nxt = FIX;
      FIX:  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Datapath: operand latch at accept, one iteration per CALC edge, sign fix in FIX.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hi <= '0; r_lo <= '0; r_b <= '0; r_acc <= '0; r_q <= '0; r_rs <= '0;
      r_cnt <= '0; r_is_div <= 1'b0; r_neg_q <= 1'b0; r_neg_r <= 1'b0; r_dz <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (w_accept) begin
          if (bus.op_code == OP_MTHI) r_hi <= bus.rs_val;
          if (bus.op_code == OP_MTLO) r_lo <= bus.rs_val;
          if (w_start) begin
            r_is_div <= bus.op_code[1];
            r_neg_q  <= w_rs_neg ^ w_rt_neg;
            r_neg_r  <= w_rs_neg;
            r_dz     <= (bus.rt_val == '0);
            r_rs     <= bus.rs_val;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_b      <= bus.op_code[1] ? w_rt_abs : w_rs_abs;
            r_q      <= bus.op_code[1] ? w_rs_abs : w_rt_abs;
`ifdef MIPS_MDU_FAST_MUL_EN
            if (!bus.op_code[1]) {r_acc, r_q} <= w_fast_prod;
`endif
          end
        end
        CALC: if (!bus.cancel) begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_is_div) begin
            r_acc <= w_div_rem;
            r_q   <= {r_q[XLEN-2:0], w_div_qbit};
          end else begin
            r_acc <= w_mul_sum[XLEN:1];
            r_q   <= {w_mul_sum[0], r_q[XLEN-1:1]};
          end
        end
        FIX: if (!bus.cancel) begin
          if (!r_is_div) begin
            {r_hi, r_lo} <= w_prod;
          end else if (r_dz) begin
            r_hi <= r_rs;
            r_lo <= '1;
          end else begin
            r_hi <= r_neg_r ? -r_acc : r_acc;
            r_lo <= r_neg_q ? -r_q   : r_q;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy     = (r_state != IDLE);
  assign bus.op_ready = ~bus.busy;
  assign bus.done     = (r_state == FIX) & ~bus.cancel;
  assign bus.hi       = r_hi;
  assign bus.lo       = r_lo;
endmodule

// File: doc/mips_mdu.md
Name: mips_mdu

Overview:
- Parametrised multiply/divide unit with architectural HI/LO registers for the MIPS core.
- Sits beside the EX stage and executes MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- Multiply and divide are iterative, one bit per cycle; `busy` tells the pipeline to stall any HI/LO consumer.
- Supports cancellation on exception flush.

Parameters:
- XLEN, 32, operand and HI/LO width; must be even and at least 8.
- CNT_W, $clog2(XLEN)+1, iteration counter width; derived, do not override.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- op_valid  in  1  operation request
- op_code  in  3  mdu_op_e: MULT=0, MULTU=1, DIV=2, DIVU=3, MTHI=4, MTLO=5; 6 and 7 are ignored
- rs_val  in  XLEN  operand A (dividend / multiplicand / MTHI-MTLO source)
- rt_val  in  XLEN  operand B (divisor / multiplier)
- cancel  in  1  flush; aborts the operation in flight
- op_ready  out  1  equals ~busy
- busy  out  1  MUL/DIV operation in progress
- done  out  1  one-cycle pulse when HI/LO is written by MUL/DIV
- hi  out  XLEN  HI register
- lo  out  XLEN  LO register

Behaviour:
- Reset (async, active-low): state=IDLE; hi=0, lo=0, busy=0, done=0, op_ready=1; internal registers cleared. Reset mid-operation aborts immediately.
- Accept condition: op_valid & op_ready & ~cancel at a rising edge. Requests while busy are ignored; the requester must hold them.
- MTHI/MTLO: hi (resp. lo) takes rs_val at the accepting edge; no busy, no done.
- Signed ops:
  - Absolute values of both operands are latched.
  - Quotient/product is negated if the operand signs differ.
  - Remainder takes the dividend's sign.
- States:
  - IDLE -> CALC on accepting MULT/MULTU/DIV/DIVU; latches operands and sign flags, cnt=0.
  - CALC: one shift-add (multiply) or restoring shift-subtract (divide) step per edge; cnt++.
  - CALC -> FIX when cnt==XLEN-1 (XLEN iterations).
  - FIX: applies sign correction and writes hi/lo; done=1 for this one cycle; -> IDLE.
- Latency:
  - Accept at edge E0; busy=1 from after E0 through edge E0+XLEN+1.
  - hi/lo take new values and busy falls at edge E0+XLEN+1. That is XLEN+1 busy cycles (33 at XLEN=32).
- Result mapping:
  - MUL: {hi,lo} = 2*XLEN-bit product.
  - DIV: lo = quotient, hi = remainder.
- Divide by zero (detected at accept):
  - Full latency still runs.
  - Result is lo = all ones, hi = rs_val, for both signed and unsigned.
- Signed overflow (DIV of most-negative by -1): lo = most-negative, hi = 0. This falls out of the abs/negate datapath; no special case.
- cancel:
  - In CALC or FIX: state -> IDLE at the next edge; hi/lo unchanged; done not asserted.
  - Same edge as a FIX write: cancel wins.
  - In IDLE: blocks acceptance, including MTHI/MTLO.
- hi/lo read during busy: outputs hold the old values.

Optional Feature:
- MIPS_MDU_FAST_MUL_EN defined:
  - MULT/MULTU compute a full-width product combinationally at accept and go IDLE -> FIX directly.
  - busy high 1 cycle; hi/lo written at E0+1. Divide is unchanged.
- Not defined: multiply is iterative as above; no multiplier inferred.

Decomposition:
- Shared package mips_pkg holds:
  - typedef enum mdu_op_e;
  - localparam XLEN_DEFAULT=32;
  - mdu_state_e {IDLE, CALC, FIX}.
- One sub-module, mips_mdu_divstep: combinational single restoring-division step.
  - Inputs: partial remainder, divisor, next dividend bit.
  - Outputs: new remainder, quotient bit.
  - Instanced in CALC.

Test Plan:
- MULT rs=0xFFFFFFFD (-3), rt=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy exactly 33 cycles; done pulses exactly once.
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. MULT 0x80000000 x 0x80000000 -> hi=0x40000000, lo=0.
- DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 7/2 -> lo=3, hi=1. DIV 7/-2 -> lo=0xFFFFFFFD, hi=1.
- DIV 100/0 -> lo=0xFFFFFFFF, hi=100. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- Start DIV with hi=0xAAAA, lo=0x5555; assert cancel on busy cycle 10:
  - busy=0 next cycle; hi/lo still 0xAAAA/0x5555; no done.
  - MTLO 0x12345678 accepted the following cycle -> lo=0x12345678.
- MTHI issued while busy -> op_ready=0, hi unchanged; same MTHI held until busy falls -> accepted the next edge.
- rst_n low mid-CALC -> busy=0, hi=lo=0 immediately (async).
